// File: rtl/controlpack.sv
// Shared control-path types for the simple-viii core: opcodes, control word,
// sequencer states and instruction field positions.
package controlpack;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 4;
  localparam int DST_HI = 5;
  localparam int DST_LO = 3;
  localparam int SRC_HI = 2;
  localparam int SRC_LO = 0;

  typedef enum logic [3:0] {
    NOP = 4'h0,
    LDX = 4'h1,
    AOP = 4'h2
  } instructions_e;

  typedef enum logic [3:0] {
    ALUNOP = 4'h0,
    PASS   = 4'h1,
    ADD    = 4'h2,
    SUB    = 4'h3,
    AND    = 4'h4,
    OR     = 4'h5,
    XOR    = 4'h6,
    NOT    = 4'h7
  } alu_op_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } memory_op_e;

  typedef enum logic [2:0] {
    REG_A         = 3'd0,
    REG_B         = 3'd1,
    REG_ADDR_LOW  = 3'd2,
    REG_ADDR_HIGH = 3'd3,
    REG_C         = 3'd4,
    REG_D         = 3'd5,
    REG_E         = 3'd6,
    REG_F         = 3'd7
  } reg_addr_e;

  typedef enum logic {
    ALU = 1'b0,
    BUS = 1'b1
  } in_source_e;

  typedef enum logic {
    ADDRESS_REGISTER = 1'b0,
    CONTROL_ADDRESS  = 1'b1
  } address_source_sel_e;

  typedef enum logic [2:0] {
    IR_NOP  = 3'd0,
    INC     = 3'd1,
    DEC     = 3'd2,
    LOAD_LO = 3'd3,
    LOAD_HI = 3'd4
  } address_reg_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
  } alu_flag_t;

  typedef enum logic [2:0] {
    RESET   = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    OPERAND = 3'd3,
    EXEC    = 3'd4,
    HALTED  = 3'd5
  } seq_state_e;

  // 21 bits; the two trailing strobes belong to other datapath blocks and stay low here.
  typedef struct packed {
    alu_op_e    alu_op;
    memory_op_e memory_op;
    reg_addr_e  ControlSelReg1xD;
    reg_addr_e  ControlSelReg2xD;
    reg_addr_e  ControlSelInxD;
    in_source_e SelInSourcexS;
    logic       next_instr;
    logic       control_unit_load;
    logic       reset;
    logic       halt;
    logic       addr_reg_load;
    logic       out_en;
  } control_word_t;

  localparam control_word_t CW_IDLE = '{
    alu_op:            ALUNOP,
    memory_op:         READ,
    ControlSelReg1xD:  REG_A,
    ControlSelReg2xD:  REG_A,
    ControlSelInxD:    REG_A,
    SelInSourcexS:     ALU,
    next_instr:        1'b0,
    control_unit_load: 1'b0,
    reset:             1'b0,
    halt:              1'b0,
    addr_reg_load:     1'b0,
    out_en:            1'b0
  };

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier for the instruction register.
// An AOP whose ALU selector lies beyond NOT counts as illegal, not as AOP.
module instr_decode
  import controlpack::*;
(
  input  logic [7:0] ir,
  output logic       is_nop,
  output logic       is_ldx,
  output logic       is_aop,
  output logic       illegal
);

  logic [3:0] opcode;

  always_comb begin
    opcode  = ir[OP_HI:OP_LO];
    is_nop  = (opcode == NOP);
    is_ldx  = (opcode == LDX);
    is_aop  = (opcode == AOP) && (ir[3:0] <= NOT);
    illegal = !(is_nop || is_ldx || is_aop);
  end

endmodule

// File: rtl/micro_sequencer.sv
// Instruction sequencer: fetches opcode/operand bytes and emits one control word per cycle.
// Outputs depend only on state, IR, OPR and data_valid_i, never on data_i.
module micro_sequencer
  import controlpack::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                data_valid_i,
  input  alu_flag_t           flags_i,
  output control_word_t       cw_o,
  output address_source_sel_e addr_src_o,
  output address_reg_op_e     pc_op_o,
  output logic                reg_we_o,
  output alu_flag_t           flags_o,
  output logic                halted_o
);

  seq_state_e state;
  logic [7:0] ir;
  logic [DST_HI:SRC_LO] opr;
  logic is_nop, is_ldx, is_aop, illegal;

  instr_decode u_decode (
    .ir      (ir),
    .is_nop  (is_nop),
    .is_ldx  (is_ldx),
    .is_aop  (is_aop),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET;
      ir      <= '0;
      opr     <= '0;
      flags_o <= '0;
    end else begin
      case (state)
        RESET: state <= FETCH;
        FETCH: begin
          if (data_valid_i) begin
            ir    <= data_i[7:0];
            state <= DECODE;
          end
        end
        DECODE: begin
          if (is_nop)       state <= FETCH;
          else if (illegal) state <= HALTED;
          else              state <= OPERAND;
        end
        OPERAND: begin
          if (data_valid_i) begin
            if (is_aop) begin
              opr   <= data_i[DST_HI:SRC_LO];
              state <= EXEC;
            end else begin
              state <= FETCH;
            end
          end
        end
        EXEC: begin
          flags_o <= flags_i;
          state   <= FETCH;
        end
        HALTED:  state <= HALTED;
        default: state <= HALTED;
      endcase
    end
  end

  // The byte-accept strobes follow data_valid_i in the same cycle, so memory
  // latency adds exactly one cycle per wait.
  always_comb begin
    cw_o       = CW_IDLE;
    addr_src_o = ADDRESS_REGISTER;
    pc_op_o    = IR_NOP;
    reg_we_o   = 1'b0;
    halted_o   = 1'b0;
    case (state)
      RESET: cw_o.reset = 1'b1;
      FETCH: begin
        addr_src_o     = CONTROL_ADDRESS;
        cw_o.memory_op = READ;
        if (data_valid_i) begin
          cw_o.control_unit_load = 1'b1;
          pc_op_o                = INC;
        end
      end
      DECODE: cw_o.next_instr = is_nop;
      OPERAND: begin
        addr_src_o     = CONTROL_ADDRESS;
        cw_o.memory_op = READ;
        if (data_valid_i) begin
          pc_op_o = INC;
          if (is_ldx) begin
            cw_o.ControlSelInxD = reg_addr_e'(ir[SRC_HI:SRC_LO]);
            cw_o.SelInSourcexS  = BUS;
            cw_o.next_instr     = 1'b1;
            reg_we_o            = 1'b1;
          end
        end
      end
      EXEC: begin
        cw_o.alu_op           = alu_op_e'(ir[3:0]);
        cw_o.ControlSelReg1xD = reg_addr_e'(opr[DST_HI:DST_LO]);
        cw_o.ControlSelReg2xD = reg_addr_e'(opr[SRC_HI:SRC_LO]);
        cw_o.ControlSelInxD   = reg_addr_e'(opr[DST_HI:DST_LO]);
        cw_o.SelInSourcexS    = ALU;
        cw_o.next_instr       = 1'b1;
        reg_we_o              = (ir[3:0] != ALUNOP);
      end
      HALTED: begin
        cw_o.halt = 1'b1;
        halted_o  = 1'b1;
      end
      default: cw_o = CW_IDLE;
    endcase
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: instruction-level expectation queue
// checked every cycle, plus literal checks on key cycles.
module tb_micro_sequencer;
  import controlpack::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [7:0]          data_i;
  logic                data_valid_i;
  alu_flag_t           flags_i;
  control_word_t       cw_o;
  address_source_sel_e addr_src_o;
  address_reg_op_e     pc_op_o;
  logic                reg_we_o;
  alu_flag_t           flags_o;
  logic                halted_o;

  micro_sequencer #(.DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .flags_i      (flags_i),
    .cw_o         (cw_o),
    .addr_src_o   (addr_src_o),
    .pc_op_o      (pc_op_o),
    .reg_we_o     (reg_we_o),
    .flags_o      (flags_o),
    .halted_o     (halted_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    control_word_t cw;
    logic          asrc;
    logic [2:0]    pc;
    logic          we;
    logic          hlt;
    logic [1:0]    fl;
  } vec_t;

  vec_t          expq[$];
  vec_t          ce;
  logic [1:0]    m_flags;
  int            tests = 0;
  int            fails = 0;
  int            ncyc = 0;
  int            inc_seen = 0;
  control_word_t snap_cw;
  logic          snap_we;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Bench encodings: CONTROL_ADDRESS = 1, INC = 1.
  function automatic vec_t mk(input logic mem_phase, input logic take);
    vec_t v;
    v.cw   = '0;
    v.asrc = mem_phase;
    v.pc   = take ? 3'd1 : 3'd0;
    v.we   = 1'b0;
    v.hlt  = 1'b0;
    v.fl   = 2'b00;
    return v;
  endfunction

  function automatic vec_t v_reset();
    vec_t v = mk(1'b0, 1'b0);
    v.cw.reset = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_halt();
    vec_t v = mk(1'b0, 1'b0);
    v.cw.halt = 1'b1;
    v.hlt     = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      chk("cw",       32'(cw_o),       32'(ce.cw));
      chk("addr_src", 32'(addr_src_o), 32'(ce.asrc));
      chk("pc_op",    32'(pc_op_o),    32'(ce.pc));
      chk("reg_we",   32'(reg_we_o),   32'(ce.we));
      chk("flags",    32'(flags_o),    32'(ce.fl));
      chk("halted",   32'(halted_o),   32'(ce.hlt));
      if (pc_op_o == INC) inc_seen++;
      snap_cw = cw_o;
      snap_we = reg_we_o;
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input vec_t e);
    vec_t x = e;
    data_valid_i = v;
    data_i       = d;
    x.fl         = m_flags;
    expq.push_back(x);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] ir, input int w);
    vec_t v;
    for (int i = 0; i < w; i++) cyc(1'b0, 8'($urandom), mk(1'b1, 1'b0));
    v = mk(1'b1, 1'b1);
    v.cw.control_unit_load = 1'b1;
    cyc(1'b1, ir, v);
  endtask

  // Expected per-cycle behaviour derived from the instruction semantics.
  task automatic run_instr(input logic [7:0] ir, input logic [7:0] op, input int w1,
                           input int w2, input logic [1:0] fl);
    vec_t v;
    logic [3:0] opc;
    opc = ir[7:4];
    fetch(ir, w1);
    v = mk(1'b0, 1'b0);
    if (opc == 4'h0) begin
      v.cw.next_instr = 1'b1;
      cyc(1'b1, 8'hEE, v);
    end else if (opc == 4'h1 || (opc == 4'h2 && ir[3:0] <= 4'h7)) begin
      cyc(1'b1, 8'hEE, v);
      for (int i = 0; i < w2; i++) cyc(1'b0, 8'($urandom), mk(1'b1, 1'b0));
      v = mk(1'b1, 1'b1);
      if (opc == 4'h1) begin
        v.cw.ControlSelInxD = reg_addr_e'(ir[2:0]);
        v.cw.SelInSourcexS  = BUS;
        v.cw.next_instr     = 1'b1;
        v.we                = 1'b1;
        cyc(1'b1, op, v);
      end else begin
        cyc(1'b1, op, v);
        v = mk(1'b0, 1'b0);
        v.cw.alu_op           = alu_op_e'(ir[3:0]);
        v.cw.ControlSelReg1xD = reg_addr_e'(op[5:3]);
        v.cw.ControlSelReg2xD = reg_addr_e'(op[2:0]);
        v.cw.ControlSelInxD   = reg_addr_e'(op[5:3]);
        v.cw.SelInSourcexS    = ALU;
        v.cw.next_instr       = 1'b1;
        v.we                  = (ir[3:0] != 4'h0);
        flags_i = alu_flag_t'(fl);
        cyc(1'b1, 8'hEE, v);
        m_flags = fl;
        flags_i = alu_flag_t'(~fl);
      end
    end else begin
      cyc(1'b1, 8'hEE, v);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_flags = 2'b00;
    cyc(1'b0, 8'h00, v_reset());
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, v_reset());
  endtask

  int c0, i0;

  initial begin
    rst_n        = 1'b0;
    data_i       = 8'h00;
    data_valid_i = 1'b0;
    flags_i      = '0;
    m_flags      = 2'b00;
    @(posedge clk);
    #1;
    chk("reset_cw_reset", 32'(cw_o.reset), 32'd1);
    chk("reset_flags", 32'(flags_o), 32'd0);
    cyc(1'b0, 8'h00, v_reset());
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, v_reset());

    // NOP: FETCH then DECODE, one PC increment.
    c0 = ncyc; i0 = inc_seen;
    run_instr(8'h00, 8'h00, 0, 0, 2'b00);
    chk("nop_cycles", 32'(ncyc - c0), 32'd2);
    chk("nop_inc_once", 32'(inc_seen - i0), 32'd1);
    chk("nop_next_instr", 32'(snap_cw.next_instr), 32'd1);

    // LDX 0x12 / 0xA5 with two wait cycles on each byte.
    c0 = ncyc;
    run_instr(8'h12, 8'hA5, 2, 2, 2'b00);
    chk("ldx_cycles", 32'(ncyc - c0), 32'd7);
    chk("ldx_dst", 32'(snap_cw.ControlSelInxD), 32'd2);
    chk("ldx_src_bus", 32'(snap_cw.SelInSourcexS), 32'd1);
    chk("ldx_we", 32'(snap_we), 32'd1);
    run_instr(8'h1F, 8'h3C, 1, 0, 2'b00);

    // AOP ADD 0x22 / 0x0B with flags 01.
    c0 = ncyc;
    run_instr(8'h22, 8'h0B, 0, 0, 2'b01);
    chk("aop_cycles", 32'(ncyc - c0), 32'd4);
    chk("aop_alu_op", 32'(snap_cw.alu_op), 32'd2);
    chk("aop_reg1", 32'(snap_cw.ControlSelReg1xD), 32'd1);
    chk("aop_reg2", 32'(snap_cw.ControlSelReg2xD), 32'd3);
    chk("aop_in", 32'(snap_cw.ControlSelInxD), 32'd1);
    chk("aop_we", 32'(snap_we), 32'd1);
    chk("aop_flags", 32'(flags_o), 32'd1);

    // ALUNOP: no write, flags still latched; NOT is the last legal ALU op.
    run_instr(8'h20, 8'hC9, 1, 1, 2'b10);
    chk("alunop_we", 32'(snap_we), 32'd0);
    chk("alunop_flags", 32'(flags_o), 32'd2);
    run_instr(8'h27, 8'h3F, 0, 2, 2'b11);
    chk("not_flags", 32'(flags_o), 32'd3);

    // Unknown opcode halts; later valid pulses are ignored.
    run_instr(8'h7F, 8'h00, 1, 0, 2'b00);
    for (int i = 0; i < 4; i++) cyc(i[0], 8'h2C, v_halt());
    chk("halt_out", 32'(halted_o), 32'd1);
    chk("halt_cw", 32'(cw_o.halt), 32'd1);

    do_reset();
    chk("post_reset_flags", 32'(flags_o), 32'd0);
    run_instr(8'h2C, 8'h00, 0, 0, 2'b00);
    cyc(1'b1, 8'h12, v_halt());
    chk("bad_aluop_halt", 32'(halted_o), 32'd1);
    do_reset();

    // Reset during the accept cycle of an LDX operand.
    fetch(8'h13, 0);
    cyc(1'b0, 8'h00, mk(1'b0, 1'b0));
    cyc(1'b0, 8'h00, mk(1'b1, 1'b0));
    data_valid_i = 1'b1;
    data_i       = 8'h5A;
    #1;
    chk("abort_pre_we", 32'(reg_we_o), 32'd1);
    rst_n   = 1'b0;
    m_flags = 2'b00;
    #1;
    chk("abort_we", 32'(reg_we_o), 32'd0);
    chk("abort_cw", 32'(cw_o), 32'(v_reset().cw));
    chk("abort_pc", 32'(pc_op_o), 32'd0);
    cyc(1'b1, 8'h5A, v_reset());
    cyc(1'b0, 8'h00, v_reset());
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, v_reset());
    run_instr(8'h00, 8'h00, 1, 0, 2'b00);
    run_instr(8'h14, 8'h77, 0, 0, 2'b00);
    chk("resume_dst", 32'(snap_cw.ControlSelInxD), 32'd4);

    cyc(1'b0, 8'h00, mk(1'b1, 1'b0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Instruction-level control unit for the simple-viii core. Fetches opcode and operand bytes over the 8-bit data bus, decodes `instructions_e` opcodes, and drives one `control_word_t` per cycle into the datapath (ALU, register file, address registers). It is the producer of the control word that the datapath consumes.

## Interface
Parameters:
- `DATA_W`, default 8: data bus width; only 8 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `data_i`  in  8  memory read data (opcode or operand byte).
- `data_valid_i`  in  1  `data_i` is valid this cycle; memory may take 1..N cycles.
- `flags_i`  in  2  `alu_flag_t` from the ALU, valid in the EXEC cycle.
- `cw_o`  out  21  `control_word_t`, fully registered-state-derived (no path from `data_i`).
- `addr_src_o`  out  1  `address_source_sel_e`; `CONTROL_ADDRESS` during FETCH and OPERAND, else `ADDRESS_REGISTER`.
- `pc_op_o`  out  3  `address_reg_op_e`; `INC` on any cycle a byte is accepted, else `IR_NOP`.
- `reg_we_o`  out  1  register-file write strobe for `cw_o.ControlSelInxD`.
- `flags_o`  out  2  latched `alu_flag_t` from the last AOP.
- `halted_o`  out  1  sequencer is in HALTED.

## Operation
- States (`seq_state_e`): RESET, FETCH, DECODE, OPERAND, EXEC, HALTED.
- Idle control word `CW_IDLE`: all fields zero (`ALUNOP`, `READ`, `REG_A`, `ALU`, all flags 0).
- RESET: entered asynchronously; `cw_o` = `CW_IDLE` with `reset`=1; next state FETCH unconditionally.
- FETCH: `memory_op`=READ. Stay until `data_valid_i`. On the valid cycle: IR <= `data_i`, `control_unit_load`=1, `pc_op_o`=INC, go DECODE.
- DECODE on IR[7:4]:
  - `NOP`: `next_instr`=1, go FETCH.
  - `LDX`, `AOP`: go OPERAND.
  - Any other opcode, or `AOP` with IR[3:0] > `NOT`: go HALTED.
- OPERAND: `memory_op`=READ. Stay until `data_valid_i`; then `pc_op_o`=INC.
  - LDX: on the valid cycle, `ControlSelInxD`=IR[2:0], `SelInSourcexS`=BUS, `reg_we_o`=1, `next_instr`=1; go FETCH.
  - AOP: OPR <= `data_i`; go EXEC.
- EXEC (AOP only): `alu_op`=IR[3:0], `ControlSelReg1xD`=OPR[5:3], `ControlSelReg2xD`=OPR[2:0], `ControlSelInxD`=OPR[5:3], `SelInSourcexS`=ALU, `reg_we_o`=1, `next_instr`=1. `flags_o` <= `flags_i`; go FETCH.
  - `ALUNOP`: `reg_we_o`=0; flags are still latched.
- HALTED: `cw_o.halt`=1, `halted_o`=1, all strobes 0. Exit only via reset.
- OPR[7:6] and, for LDX, IR[3] are ignored.

## Timing
- Reset values: state RESET, IR=0, OPR=0, `flags_o`=0, `halted_o`=0, `reg_we_o`=0, `pc_op_o`=IR_NOP, `addr_src_o`=ADDRESS_REGISTER, `cw_o`=CW_IDLE with `reset`=1.
- Latency with zero memory wait, counting from the first FETCH cycle:
  - NOP: 2 cycles.
  - LDX: 3 cycles.
  - AOP: 4 cycles.
- Each memory wait cycle adds exactly one cycle.
- Handshake: a byte is consumed only on a cycle with `data_valid_i`=1 in FETCH or OPERAND. `data_valid_i` in any other state is ignored.
- `reg_we_o` and `next_instr` are single-cycle pulses.
- A reset asserted mid-instruction aborts it immediately (asynchronous). No partial register write occurs after the reset edge.

## Structure
- Add to `controlpack`:
  - `seq_state_e` (3 bits).
  - `CW_IDLE` constant.
  - Field-slice localparams: `OP_HI`=7, `OP_LO`=4, `DST_HI`=5, `DST_LO`=3, `SRC_HI`=2, `SRC_LO`=0.
- One combinational sub-module, `instr_decode`: IR -> {is_nop, is_ldx, is_aop, illegal}. The FSM and output logic stay in `micro_sequencer`.

## Test plan
- Reset, then byte 0x00 with `data_valid_i` on the 1st FETCH cycle -> `reset`=1 for 1 cycle; `next_instr` pulses in DECODE (cycle 3); `pc_op_o`=INC exactly once.
- LDX 0x12, operand 0xA5, memory with 2 wait cycles each -> `reg_we_o`=1 with `ControlSelInxD`=REG_ADDR_LOW and `SelInSourcexS`=BUS on the 0xA5 valid cycle; total 7 cycles.
- AOP ADD 0x22, operand 0x0B, `flags_i`=2'b01 -> EXEC has `alu_op`=ADD, Reg1=REG_ADDR_HIGH? no: OPR[5:3]=1 so Reg1=REG_B and In=REG_B, Reg2=REG_ADDR_HIGH, `reg_we_o`=1; `flags_o`=2'b01 afterwards.
- Opcode 0x7F, then 0x2C -> HALTED, `halted_o`=1, `cw.halt`=1; further `data_valid_i` pulses are ignored.
- `rst_n` low during OPERAND of LDX -> outputs equal reset values in the same cycle; no `reg_we_o` pulse; FETCH resumes after release.
